// File: rtl/minterm_scanner_pkg.sv
// Shared definitions for the minterm scanner: default input count and FSM state encoding.
package minterm_scanner_pkg;

    localparam int N_DEFAULT = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_EMIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/minterm_scanner_lsb_encoder.sv
// Lowest-set-bit priority encoder: returns the index of the least significant 1 and an any-set flag.
module lsb_encoder #(
    parameter int N = 3
) (
    input  logic [2**N-1:0] vec,
    output logic [N-1:0]    idx,
    output logic            any
);

    localparam int W = 2**N;

    logic [W-1:0] onehot;

    // Two's-complement trick isolates the lowest set bit as a one-hot word.
    assign onehot = vec & (~vec + W'(1));
    assign any    = |vec;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_idx_bit
            logic [W-1:0] mask;
            for (gj = 0; gj < W; gj++) begin : g_mask
                assign mask[gj] = (((gj >> gi) % 2) == 1);
            end
            assign idx[gi] = |(onehot & mask);
        end
    endgenerate

endmodule

// File: rtl/xor_nor_fn.sv
// Three-input XOR/NOR function under test: f = ~((x0 ^ x1) | x2), true at rows 0 and 6.
module xor_nor_fn (
    input  logic [0:2] x,
    output logic       f
);

    assign f = ~((x[0] ^ x[1]) | x[2]);

endmodule

// File: rtl/minterm_scanner.sv
// Walks every row of an N-input truth table, captures f, then streams the set-row indices
// in ascending order over a valid/ready handshake.
module minterm_scanner
    import minterm_scanner_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [0:N-1]      data,
    input  logic              f,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N-1:0]      m_idx,
    output logic [2**N-1:0]   truth_table,
    output logic [N:0]        count,
    output logic              busy,
    output logic              done
);

    localparam int ROWS = 2**N;

    state_t          state_reg, state_next;
    logic [N-1:0]    row_reg, row_next;
    logic [ROWS-1:0] table_reg, table_next;
    logic [ROWS-1:0] work_reg, work_next;
    logic [ROWS-1:0] scan_table;
    logic [N:0]      count_reg, count_next;
    logic [N-1:0]    enc_idx;
    logic            enc_any;

    lsb_encoder #(.N(N)) u_lsb (
        .vec (work_reg),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        table_next = table_reg;
        count_next = count_reg;
        work_next  = work_reg;

        scan_table          = table_reg;
        scan_table[row_reg] = f;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SCAN;
                    row_next   = '0;
                    table_next = '0;
                    count_next = '0;
                    work_next  = '0;
                end
            end
            ST_SCAN: begin
                table_next = scan_table;
                count_next = count_reg + (N+1)'(f);
                row_next   = row_reg + N'(1);
                // Last row: hand the finished table to the emitter, or skip it when empty.
                if (&row_reg) begin
                    work_next  = scan_table;
                    state_next = (scan_table == '0) ? ST_DONE : ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (!enc_any) begin
                    state_next = ST_DONE;
                end else if (m_ready) begin
                    work_next = work_reg & ~(ROWS'(1) << enc_idx);
                    if (work_next == '0) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            row_reg   <= '0;
            table_reg <= '0;
            count_reg <= '0;
            work_reg  <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            table_reg <= table_next;
            count_reg <= count_next;
            work_reg  <= work_next;
        end
    end

    // Emission is driven from the registered working copy, so it holds steady under back-pressure.
    assign data        = (state_reg == ST_SCAN) ? row_reg : '0;
    assign m_valid     = (state_reg == ST_EMIT) && enc_any;
    assign m_idx       = m_valid ? enc_idx : '0;
    assign truth_table = table_reg;
    assign count       = count_reg;
    assign busy        = (state_reg == ST_SCAN) || (state_reg == ST_EMIT);
    assign done        = (state_reg == ST_DONE);

endmodule
